engine_reg_bus_arbiter: RTL and testbench
=========================================

# engine_reg_bus_arbiter

Shares the single register-access bus of the engine's controlling register block between several bus masters. Each master posts one read or write request; a round-robin arbiter picks one and a small FSM drives exactly one access strobe to the register block. It then returns an acknowledge pulse, with read data for reads, to the winner. The block sits between the masters (CPU bridge, debug port, test sequencer) and the controlling register block.

## Interface
- NUM_MASTERS, 4, number of requesters (2..8)
- ADDR_WIDTH, 33, register bus address width
- WDATA_WIDTH, 33, register bus write data width
- RDATA_WIDTH, 21, register bus read data width
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- m_req  in  NUM_MASTERS  per-master request, level
- m_write  in  NUM_MASTERS  per-master direction: 1 = write, 0 = read
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*WDATA_WIDTH  packed per-master write data
- m_ack  out  NUM_MASTERS  one-hot, one-cycle completion pulse
- m_rdata  out  RDATA_WIDTH  read data, valid only while m_ack is high for a read
- address  out  ADDR_WIDTH  to register block
- write_enable  out  1  one-cycle write strobe
- write_data  out  WDATA_WIDTH  to register block
- read_enable  out  1  one-cycle read strobe
- read_data  in  RDATA_WIDTH  combinational read data from register block
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If m_req is nonzero, the round-robin picker selects winner g.
  - Register g, m_write[g], m_addr[g] and m_wdata[g] into the bus registers, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Assert write_enable or read_enable for exactly this cycle. The two strobes are never high together.
  - Capture read_data into the m_rdata register at the end of the cycle (reads only).
  - Go to RESP.
- RESP:
  - m_ack[g] = 1 for one cycle, then go to IDLE.
  - m_req is not sampled in RESP, so the acked master's held request cannot retrigger.
- Round-robin pointer:
  - The pointer holds the last granted index and updates on each grant.
  - Search order starts at pointer+1 and wraps modulo NUM_MASTERS.
  - Reset value is NUM_MASTERS-1, so master 0 has top priority after reset.
- Requester rules:
  - Hold m_req, m_write, m_addr and m_wdata stable until m_ack.
  - Drop m_req, or present a new transaction, in the cycle after the ack.
- Dropping m_req before the grant is legal; the request is simply not seen.
- Once granted, the transaction is already latched; it completes and acks even if m_req drops.
- address and write_data hold their last value outside ACCESS.
- m_rdata holds its last value.
- No timeout and no error response: the register block always completes in one cycle.

## Timing
- Reset (reset low at a rising edge) forces:
  - state IDLE, pointer NUM_MASTERS-1
  - m_ack 0, m_rdata 0, address 0, write_data 0
  - write_enable 0, read_enable 0, busy 0
- Reset mid-transaction:
  - The in-flight transaction is dropped with no ack.
  - A strobe scheduled for the next cycle is not issued.
  - The master must reissue the request.
- Latency, request first sampled high at edge k:
  - strobe high in cycle k+1 (ACCESS)
  - m_ack high in cycle k+2 (RESP)
- Throughput: one transaction per 3 cycles; back-to-back grants are IDLE→ACCESS→RESP→IDLE→ACCESS.
- Simultaneous requests: exactly one winner per IDLE decision; losers wait with m_req held.
- Fairness: under full load, each master is granted within NUM_MASTERS transactions (3*NUM_MASTERS cycles).
- busy rises in the cycle after the request is sampled and falls in the cycle after RESP.

## Structure
- Package engine_reg_bus_pkg:
  - state enum (IDLE, ACCESS, RESP), 2-bit encoding
  - default width constants (ADDR_WIDTH 33, WDATA_WIDTH 33, RDATA_WIDTH 21)
  - MAX_MASTERS = 8
- Sub-module engine_rr_picker:
  - combinational inputs: req vector and pointer
  - outputs: one-hot grant, encoded index, any_req
  - reusable by other engine arbiters
- Top-level block holds the FSM, bus registers, pointer and response registers.

## Test plan
- Single write: after reset, m_req=4'b0001, m_write[0]=1, addr 0xAA, wdata 0x1234:
  - next cycle address=0xAA, write_data=0x1234, write_enable=1
  - following cycle m_ack=4'b0001; read_enable never high
- Single read: master 2 reads addr 0xAA while read_data=0x00042:
  - read_enable pulses once
  - m_ack=4'b0100 with m_rdata=0x00042 in the same cycle
- Round-robin: all four masters request continuously from reset:
  - grant order 0,1,2,3,0
  - acks spaced exactly 3 cycles apart
- Withdraw and hold:
  - master 1 raises m_req then drops it before any grant: no strobe, no ack
  - master 3 drops m_req during ACCESS: its ack still pulses
- Reset mid-operation: reset low during ACCESS:
  - all outputs zero next cycle, no ack issued
  - after release, master 0 wins first
- Strobe exclusivity: random traffic for 10k cycles; assert:
  - write_enable and read_enable never high together
  - m_ack always one-hot or zero
  - every granted request gets exactly one ack

Source files
------------

// File: rtl/engine_reg_bus_arbiter_pkg.sv
// engine_reg_bus_pkg: shared state encoding and default widths for the register-bus arbiter
package engine_reg_bus_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam int ADDR_WIDTH  = 33;
  localparam int WDATA_WIDTH = 33;
  localparam int RDATA_WIDTH = 21;
  localparam int MAX_MASTERS = 8;
endpackage

// File: rtl/engine_reg_bus_arbiter_if.sv
// engine_reg_bus_arbiter_if: requester and register-block signals of the shared register bus
interface engine_reg_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = engine_reg_bus_pkg::ADDR_WIDTH,
  parameter int WDATA_WIDTH = engine_reg_bus_pkg::WDATA_WIDTH,
  parameter int RDATA_WIDTH = engine_reg_bus_pkg::RDATA_WIDTH
);
  logic [NUM_MASTERS-1:0]             m_req;
  logic [NUM_MASTERS-1:0]             m_write;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr;
  logic [NUM_MASTERS*WDATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]             m_ack;
  logic [RDATA_WIDTH-1:0]             m_rdata;
  logic [ADDR_WIDTH-1:0]              address;
  logic                               write_enable;
  logic [WDATA_WIDTH-1:0]             write_data;
  logic                               read_enable;
  logic [RDATA_WIDTH-1:0]             read_data;
  logic                               busy;
  // arbiter side
  modport slave (
    input  m_req, m_write, m_addr, m_wdata, read_data,
    output m_ack, m_rdata, address, write_enable, write_data, read_enable, busy
  );
  // requesters plus register block side
  modport master (
    output m_req, m_write, m_addr, m_wdata, read_data,
    input  m_ack, m_rdata, address, write_enable, write_data, read_enable, busy
  );
endinterface

// File: rtl/engine_rr_picker.sv
// engine_rr_picker: combinational round-robin pick, searching from ptr+1 with wraparound
module engine_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);
  // scan farthest offset first so the nearest requester after ptr overwrites and wins
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
  end
  assign any_req = |req;
endmodule

// File: rtl/engine_reg_bus_arbiter.sv
// engine_reg_bus_arbiter: round-robin sharing of the register-block access bus between masters
module engine_reg_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = engine_reg_bus_pkg::ADDR_WIDTH,
  parameter int WDATA_WIDTH = engine_reg_bus_pkg::WDATA_WIDTH,
  parameter int RDATA_WIDTH = engine_reg_bus_pkg::RDATA_WIDTH
) (
  input logic                      clock,
  input logic                      reset,
  engine_reg_bus_arbiter_if.slave  bus
);
  import engine_reg_bus_pkg::*;
  localparam int IW = $clog2(NUM_MASTERS);
  state_t                 state;
  state_t                 state_nxt;
  logic [IW-1:0]          ptr;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic                   wr_q;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   any_req;
  logic                   take;
  engine_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req     (bus.m_req),
    .ptr     (ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );
  assign take = (state == IDLE) && any_req;
  // state register
  always_ff @(posedge clock)
    state <= !reset ? IDLE : state_nxt;
  // next state and strobes; requests are only looked at in IDLE
  always_comb begin
    state_nxt        = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
    bus.write_enable = (state == ACCESS) && wr_q;
    bus.read_enable  = (state == ACCESS) && !wr_q;
    bus.m_ack        = (state == RESP) ? gnt_q : '0;
    bus.busy         = state != IDLE;
  end
  // latch the winner's transaction on grant and the read data at the end of ACCESS
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr            <= IW'(NUM_MASTERS - 1);
      gnt_q          <= '0;
      wr_q           <= 1'b0;
      bus.address    <= '0;
      bus.write_data <= '0;
      bus.m_rdata    <= '0;
    end else begin
      if (take) begin
        ptr            <= pick_idx;
        gnt_q          <= pick_grant;
        wr_q           <= bus.m_write[pick_idx];
        bus.address    <= bus.m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        bus.write_data <= bus.m_wdata[pick_idx*WDATA_WIDTH +: WDATA_WIDTH];
      end
      if (state == ACCESS && !wr_q)
        bus.m_rdata <= bus.read_data;
    end
  end
endmodule

// File: tb/tb_engine_reg_bus_arbiter.sv
// tb_engine_reg_bus_arbiter: directed and random checks of the register-bus arbiter
module tb_engine_reg_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 33;
  localparam int WW = 33;
  localparam int RW = 21;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rd_sel = 1'b0;
  logic [RW-1:0] rd_val = '0;
  int passed = 0;
  int total = 0;
  engine_reg_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW)) bus ();
  engine_reg_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  assign bus.read_data = rd_sel ? (bus.address[RW-1:0] ^ 21'h15555) : rd_val;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_master(int i, logic wr, logic [AW-1:0] a, logic [WW-1:0] d);
    bus.m_write[i] = wr;
    bus.m_addr[i*AW +: AW] = a;
    bus.m_wdata[i*WW +: WW] = d;
  endtask

  task automatic test_reset();
    bus.m_req = '0; bus.m_write = '0; bus.m_addr = '0; bus.m_wdata = '0;
    reset = 1'b0;
    tick(); tick();
    total++; if (bus.m_ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", bus.m_ack); else passed++;
    total++; if (bus.m_rdata !== 21'h0) $display("FAIL reset_rdata got %h want 0", bus.m_rdata); else passed++;
    total++; if (bus.address !== 33'h0 || bus.write_data !== 33'h0) $display("FAIL reset_bus got %h/%h want 0/0", bus.address, bus.write_data); else passed++;
    total++; if ({bus.write_enable, bus.read_enable, bus.busy} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {bus.write_enable, bus.read_enable, bus.busy}); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int re_seen = 0;
    set_master(0, 1'b1, 33'hAA, 33'h1234);
    bus.m_req = 4'b0001;
    tick();
    re_seen += bus.read_enable;
    total++; if (bus.address !== 33'hAA) $display("FAIL wr_addr got %h want aa", bus.address); else passed++;
    total++; if (bus.write_data !== 33'h1234) $display("FAIL wr_data got %h want 1234", bus.write_data); else passed++;
    total++; if (bus.write_enable !== 1'b1 || bus.m_ack !== 4'b0000) $display("FAIL wr_strobe got we=%b ack=%b want 1/0000", bus.write_enable, bus.m_ack); else passed++;
    tick();
    re_seen += bus.read_enable;
    total++; if (bus.m_ack !== 4'b0001 || bus.write_enable !== 1'b0) $display("FAIL wr_ack got ack=%b we=%b want 0001/0", bus.m_ack, bus.write_enable); else passed++;
    bus.m_req = '0;
    tick();
    re_seen += bus.read_enable;
    total++; if (bus.m_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL wr_idle got ack=%b busy=%b want 0000/0", bus.m_ack, bus.busy); else passed++;
    total++; if (re_seen != 0) $display("FAIL wr_no_read got %0d read strobes want 0", re_seen); else passed++;
  endtask

  task automatic test_single_read();
    int re_cnt = 0;
    set_master(2, 1'b0, 33'hAA, 33'h0);
    rd_val = 21'h00042;
    bus.m_req = 4'b0100;
    tick();
    re_cnt += bus.read_enable;
    total++; if (bus.read_enable !== 1'b1 || bus.write_enable !== 1'b0) $display("FAIL rd_strobe got re=%b we=%b want 1/0", bus.read_enable, bus.write_enable); else passed++;
    tick();
    re_cnt += bus.read_enable;
    total++; if (bus.m_ack !== 4'b0100) $display("FAIL rd_ack got %b want 0100", bus.m_ack); else passed++;
    total++; if (bus.m_rdata !== 21'h00042) $display("FAIL rd_data got %h want 00042", bus.m_rdata); else passed++;
    bus.m_req = '0;
    rd_val = 21'h1FFFF;
    for (int c = 0; c < 3; c++) begin tick(); re_cnt += bus.read_enable; end
    total++; if (re_cnt != 1) $display("FAIL rd_once got %0d read strobes want 1", re_cnt); else passed++;
    total++; if (bus.m_rdata !== 21'h00042) $display("FAIL rd_hold got %h want 00042", bus.m_rdata); else passed++;
  endtask

  task automatic test_round_robin();
    int seen[$];
    int at[$];
    for (int i = 0; i < N; i++) set_master(i, 1'b1, 33'(32'h100 + i), 33'(32'h200 + i));
    bus.m_req = 4'b1111;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 24 && seen.size() < 5; c++) begin
      tick();
      if (bus.write_enable) begin
        total++;
        if (bus.address !== 33'(32'h100 + (seen.size() % N))) $display("FAIL rr_addr got %h want %h", bus.address, 32'h100 + (seen.size() % N)); else passed++;
      end
      if (bus.m_ack != 0) begin seen.push_back(oh_idx(bus.m_ack)); at.push_back(c); end
    end
    bus.m_req = '0;
    total++; if (seen.size() != 5) $display("FAIL rr_count got %0d acks want 5", seen.size()); else passed++;
    for (int k = 0; k < seen.size(); k++) begin
      total++; if (seen[k] != k % N) $display("FAIL rr_order[%0d] got %0d want %0d", k, seen[k], k % N); else passed++;
      if (k > 0) begin
        total++; if (at[k] - at[k-1] != 3) $display("FAIL rr_spacing[%0d] got %0d want 3", k, at[k] - at[k-1]); else passed++;
      end
    end
    tick(); tick();
  endtask

  task automatic test_withdraw();
    int act = 0;
    set_master(0, 1'b1, 33'h10, 33'h55);
    set_master(1, 1'b0, 33'h20, 33'h0);
    bus.m_req = 4'b0001;
    tick();
    bus.m_req = 4'b0011;
    tick();
    total++; if (bus.m_ack !== 4'b0001) $display("FAIL wd_m0_ack got %b want 0001", bus.m_ack); else passed++;
    bus.m_req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      act += int'(bus.write_enable) + int'(bus.read_enable) + int'(bus.m_ack != 0);
    end
    total++; if (act != 0) $display("FAIL wd_m1_unseen got %0d events want 0", act); else passed++;
  endtask

  task automatic test_hold();
    set_master(3, 1'b0, 33'h33, 33'h0);
    bus.m_req = 4'b1000;
    tick();
    total++; if (bus.read_enable !== 1'b1 || bus.address !== 33'h33) $display("FAIL hold_access got re=%b addr=%h want 1/33", bus.read_enable, bus.address); else passed++;
    bus.m_req = '0;
    tick();
    total++; if (bus.m_ack !== 4'b1000) $display("FAIL hold_ack got %b want 1000", bus.m_ack); else passed++;
    tick();
    total++; if (bus.m_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL hold_idle got ack=%b busy=%b want 0000/0", bus.m_ack, bus.busy); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) set_master(i, 1'b1, 33'(32'h300 + i), 33'(32'h400 + i));
    bus.m_req = 4'b0100;
    tick();
    total++; if (bus.write_enable !== 1'b1 || bus.address !== 33'h302) $display("FAIL rm_access got we=%b addr=%h want 1/302", bus.write_enable, bus.address); else passed++;
    reset = 1'b0;
    tick();
    total++; if (bus.m_ack !== 4'b0000) $display("FAIL rm_no_ack got %b want 0000", bus.m_ack); else passed++;
    total++; if ({bus.write_enable, bus.read_enable, bus.busy} !== 3'b000) $display("FAIL rm_strobes got %b want 000", {bus.write_enable, bus.read_enable, bus.busy}); else passed++;
    total++; if (bus.address !== 33'h0 || bus.write_data !== 33'h0 || bus.m_rdata !== 21'h0) $display("FAIL rm_regs got %h/%h/%h want 0/0/0", bus.address, bus.write_data, bus.m_rdata); else passed++;
    reset = 1'b1;
    bus.m_req = 4'b1111;
    tick();
    total++; if (bus.address !== 33'h300) $display("FAIL rm_first_addr got %h want 300", bus.address); else passed++;
    tick();
    total++; if (bus.m_ack !== 4'b0001) $display("FAIL rm_first_ack got %b want 0001", bus.m_ack); else passed++;
    bus.m_req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic          pend [N];
    logic          wr   [N];
    logic [AW-1:0] a    [N];
    logic [WW-1:0] d    [N];
    int            wt   [N];
    logic          ps_v = 1'b0;
    logic          ps_w = 1'b0;
    logic [AW-1:0] ps_a = '0;
    logic [WW-1:0] ps_d = '0;
    int starts = 0, acks = 0, strobes = 0, errs = 0;
    rd_sel = 1'b1;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; wr[i] = 1'b0; a[i] = '0; d[i] = '0; wt[i] = 0; end
    for (int c = 0; c < 10030; c++) begin
      tick();
      if (bus.write_enable && bus.read_enable) begin errs++; $display("FAIL rnd_excl cycle %0d both strobes high", c); end
      if (bus.m_ack != 0) begin
        int g;
        g = oh_idx(bus.m_ack);
        acks++;
        if (!$onehot(bus.m_ack)) begin errs++; $display("FAIL rnd_onehot got %b want one-hot", bus.m_ack); end
        else if (!pend[g]) begin errs++; $display("FAIL rnd_spurious ack %b for idle master", bus.m_ack); end
        else if (!ps_v || ps_w !== wr[g] || ps_a !== a[g] || (wr[g] && ps_d !== d[g])) begin
          errs++; $display("FAIL rnd_access m%0d got v=%b w=%b a=%h want w=%b a=%h", g, ps_v, ps_w, ps_a, wr[g], a[g]);
        end else if (!wr[g] && bus.m_rdata !== (a[g][RW-1:0] ^ 21'h15555)) begin
          errs++; $display("FAIL rnd_rdata m%0d got %h want %h", g, bus.m_rdata, a[g][RW-1:0] ^ 21'h15555);
        end
        if (g >= 0) begin pend[g] = 1'b0; bus.m_req[g] = 1'b0; wt[g] = 0; end
      end
      ps_v = bus.write_enable || bus.read_enable;
      ps_w = bus.write_enable;
      ps_a = bus.address;
      ps_d = bus.write_data;
      if (ps_v) strobes++;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          wt[i]++;
          if (wt[i] == 3 * N + 4) begin errs++; $display("FAIL rnd_starve m%0d waited %0d cycles want <= %0d", i, wt[i], 3 * N + 3); end
        end else if (c < 10000 && !bus.m_req[i] && bus.m_ack[i] !== 1'b1 && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; wr[i] = 1'($urandom); a[i] = AW'({$urandom, $urandom}); d[i] = WW'({$urandom, $urandom});
          set_master(i, wr[i], a[i], d[i]);
          bus.m_req[i] = 1'b1;
          starts++;
        end
      end
    end
    rd_sel = 1'b0;
    total++; if (errs != 0) $display("FAIL rnd_errors got %0d want 0", errs); else passed++;
    total++; if (acks != starts || starts == 0) $display("FAIL rnd_ack_count got %0d acks want %0d", acks, starts); else passed++;
    total++; if (strobes != acks) $display("FAIL rnd_strobe_count got %0d strobes want %0d", strobes, acks); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rnd_drain got busy=%b want 0", bus.busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_withdraw();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
